regfile_write_buffer: RTL and testbench

//  Write-back buffer sitting directly upstream of the dual-write-port register file.

---
 rtl/regfile_write_buffer_pkg.sv | 35 +++
 rtl/regfile_write_buffer_wb_fifo.sv | 63 ++++++
 rtl/regfile_write_buffer.sv | 132 +++++++++++++
 tb/tb_regfile_write_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file write-back buffer: default widths shared with the
// register file and the bit offsets of the packed FIFO entry {v1,a1,d1,v2,a2,d2}.
package regfile_write_buffer_pkg;

    localparam int unsigned DefAddrW = 5;
    localparam int unsigned DefDataW = 32;

    // Slot-2 data occupies the LSBs; slot-1 valid is the MSB.
    localparam int unsigned OffD2 = 0;

    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return 2 + 2 * aw + 2 * dw;
    endfunction

    function automatic int unsigned off_a2(input int unsigned aw, input int unsigned dw);
        return OffD2 + dw + 0 * aw;
    endfunction

    function automatic int unsigned off_v2(input int unsigned aw, input int unsigned dw);
        return off_a2(aw, dw) + aw;
    endfunction

    function automatic int unsigned off_d1(input int unsigned aw, input int unsigned dw);
        return off_v2(aw, dw) + 1;
    endfunction

    function automatic int unsigned off_a1(input int unsigned aw, input int unsigned dw);
        return off_d1(aw, dw) + dw;
    endfunction

    function automatic int unsigned off_v1(input int unsigned aw, input int unsigned dw);
        return off_a1(aw, dw) + aw;
    endfunction

endpackage

// File: rtl/regfile_write_buffer_wb_fifo.sv
// Synchronous FIFO holding packed write-back pairs; (log2(Depth)+1)-bit pointers distinguish
// full from empty without a separate occupancy register.
module regfile_write_buffer_wb_fifo #(
    parameter int unsigned Width = 76,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = 1;

    logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push, do_pop;

    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

    // A flush cycle discards any concurrent push or pop.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the dual-write-port register file: queues lane pairs, drains one
// pair per cycle through registered write ports, suppressing r0 writes and merging same-address pairs.
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = 4,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                      clk_t,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_v1,
    input  logic [ADDR_W-1:0]         in_a1,
    input  logic [DATA_W-1:0]         in_d1,
    input  logic                      in_v2,
    input  logic [ADDR_W-1:0]         in_a2,
    input  logic [DATA_W-1:0]         in_d2,
    input  logic                      drain_en,
    output logic [ADDR_W-1:0]         wa1,
    output logic [ADDR_W-1:0]         wa2,
    output logic [DATA_W-1:0]         wd1,
    output logic [DATA_W-1:0]         wd2,
    output logic                      w1_en,
    output logic                      w2_en,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      conflict
);

    localparam int unsigned EntryW = entry_width(ADDR_W, DATA_W);
    localparam int unsigned OffA2  = off_a2(ADDR_W, DATA_W);
    localparam int unsigned OffV2  = off_v2(ADDR_W, DATA_W);
    localparam int unsigned OffD1  = off_d1(ADDR_W, DATA_W);
    localparam int unsigned OffA1  = off_a1(ADDR_W, DATA_W);
    localparam int unsigned OffV1  = off_v1(ADDR_W, DATA_W);

    logic [EntryW-1:0] wdata, head;
    logic              full, empty, push, pop;
    logic              h_v1, h_v2, live1, live2, merge;
    logic [ADDR_W-1:0] h_a1, h_a2;
    logic [DATA_W-1:0] h_d1, h_d2;

    logic [ADDR_W-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
    logic [DATA_W-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
    logic              w1_en_q, w1_en_d, w2_en_q, w2_en_d;
    logic              conflict_q, conflict_d;

    // No pass-through: a full buffer refuses even when it pops in the same cycle.
    assign in_ready = rst_n & ~flush & ~full;
    assign push     = in_valid & in_ready & (in_v1 | in_v2);
    assign pop      = drain_en & ~empty & ~flush;
    assign wdata    = {in_v1, in_a1, in_d1, in_v2, in_a2, in_d2};

    regfile_write_buffer_wb_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_wb_fifo (
        .clk_i   (clk_t),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign h_v1 = head[OffV1];
    assign h_a1 = head[OffA1 +: ADDR_W];
    assign h_d1 = head[OffD1 +: DATA_W];
    assign h_v2 = head[OffV2];
    assign h_a2 = head[OffA2 +: ADDR_W];
    assign h_d2 = head[OffD2 +: DATA_W];

    assign live1 = h_v1 & ~(ZERO_REG && (h_a1 == '0));
    assign live2 = h_v2 & ~(ZERO_REG && (h_a2 == '0));
    // Slot 2 is younger, so on an address match only its write survives.
    assign merge = live1 & live2 & (h_a1 == h_a2);

    always_comb begin
        wa1_d      = wa1_q;
        wa2_d      = wa2_q;
        wd1_d      = wd1_q;
        wd2_d      = wd2_q;
        w1_en_d    = 1'b0;
        w2_en_d    = 1'b0;
        conflict_d = 1'b0;
        if (pop) begin
            wa1_d      = h_a1;
            wa2_d      = h_a2;
            wd1_d      = h_d1;
            wd2_d      = h_d2;
            w1_en_d    = live1 & ~merge;
            w2_en_d    = live2;
            conflict_d = merge;
        end
    end

    always_ff @(posedge clk_t or negedge rst_n) begin
        if (!rst_n) begin
            wa1_q      <= '0;
            wa2_q      <= '0;
            wd1_q      <= '0;
            wd2_q      <= '0;
            w1_en_q    <= 1'b0;
            w2_en_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            wa1_q      <= wa1_d;
            wa2_q      <= wa2_d;
            wd1_q      <= wd1_d;
            wd2_q      <= wd2_d;
            w1_en_q    <= w1_en_d;
            w2_en_q    <= w2_en_d;
            conflict_q <= conflict_d;
        end
    end

    assign wa1      = wa1_q;
    assign wa2      = wa2_q;
    assign wd1      = wd1_q;
    assign wd2      = wd2_q;
    assign w1_en    = w1_en_q;
    assign w2_en    = w2_en_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: expected register-file writes are queued when a pair is
// offered and compared as the DUT issues them; a small register-file model gives read-back.
module tb_regfile_write_buffer;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic          en1;
        logic          en2;
        logic          conf;
        logic [AW-1:0] wa1;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd1;
        logic [DW-1:0] wd2;
    } exp_t;

    logic          clk_t, rst_n, flush, in_valid, in_ready, drain_en;
    logic          in_v1, in_v2, w1_en, w2_en, conflict;
    logic [AW-1:0] in_a1, in_a2, wa1, wa2, ra1, ra2;
    logic [DW-1:0] in_d1, in_d2, wd1, wd2, rd1, rd2;
    logic [2:0]    count;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [DW-1:0] rf [32];

    regfile_write_buffer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .ZERO_REG (1'b1)
    ) dut (
        .clk_t    (clk_t),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_v1    (in_v1),
        .in_a1    (in_a1),
        .in_d1    (in_d1),
        .in_v2    (in_v2),
        .in_a2    (in_a2),
        .in_d2    (in_d2),
        .drain_en (drain_en),
        .wa1      (wa1),
        .wa2      (wa2),
        .wd1      (wd1),
        .wd2      (wd2),
        .w1_en    (w1_en),
        .w2_en    (w2_en),
        .count    (count),
        .conflict (conflict)
    );

    initial clk_t = 1'b0;
    always #5 clk_t = ~clk_t;

    // Register file driven by the buffer; port 2 written last so the younger write wins.
    always @(posedge clk_t) begin
        if (rst_n && w1_en) rf[wa1] <= wd1;
        if (rst_n && w2_en) rf[wa2] <= wd2;
    end
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        exp_t e;
        logic l1, l2;
        l1 = v1 && (a1 != 0);
        l2 = v2 && (a2 != 0);
        e.conf = l1 && l2 && (a1 == a2);
        e.en1  = l1 && !e.conf;
        e.en2  = l2;
        e.wa1  = a1;
        e.wa2  = a2;
        e.wd1  = d1;
        e.wd2  = d2;
        return e;
    endfunction

    // Scoreboard: every issued write must match the oldest outstanding expectation.
    always @(negedge clk_t) begin
        if (rst_n && (w1_en || w2_en || conflict)) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {29'd0, w1_en, w2_en, conflict}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("w1_en", {31'd0, w1_en}, {31'd0, mon_e.en1});
                chk("w2_en", {31'd0, w2_en}, {31'd0, mon_e.en2});
                chk("conflict", {31'd0, conflict}, {31'd0, mon_e.conf});
                if (mon_e.en1) begin
                    chk("wa1", {27'd0, wa1}, {27'd0, mon_e.wa1});
                    chk("wd1", wd1, mon_e.wd1);
                end
                if (mon_e.en2) begin
                    chk("wa2", {27'd0, wa2}, {27'd0, mon_e.wa2});
                    chk("wd2", wd2, mon_e.wd2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_t);
        #1;
    endtask

    task automatic offer(input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         input bit accept);
        exp_t e;
        in_valid = 1'b1;
        in_v1 = v1; in_a1 = a1; in_d1 = d1;
        in_v2 = v2; in_a2 = a2; in_d2 = d2;
        e = mk(v1, a1, d1, v2, a2, d2);
        if (accept && (e.en1 || e.en2 || e.conf)) sb.push_back(e);
    endtask

    task automatic drain_wait(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
        in_v1 = 1'b0; in_a1 = '0; in_d1 = '0; in_v2 = 1'b0; in_a2 = '0; in_d2 = '0;
        ra1 = '0; ra2 = '0;

        #12;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_enables", {29'd0, w1_en, w2_en, conflict}, 32'd0);
        chk("rst_wa_wd", wd1 | wd2 | {27'd0, wa1 | wa2}, 32'd0);
        @(negedge clk_t);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // 1) plain pair, two-cycle latency
        offer(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd7, 32'hBBBB_0002, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t1_count", {29'd0, count}, 32'd1);
        chk("t1_not_early", {31'd0, w1_en}, 32'd0);
        step();
        chk("t1_latency", {30'd0, w1_en, w2_en}, 32'd3);
        step();
        ra1 = 5'd3; ra2 = 5'd7;
        #1;
        chk("t1_rd1", rd1, 32'hAAAA_0001);
        chk("t1_rd2", rd2, 32'hBBBB_0002);
        chk("t1_idle", {30'd0, w1_en, w2_en}, 32'd0);

        // 2) same-address merge
        offer(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("t2_conflict", {31'd0, conflict}, 32'd1);
        step();
        chk("t2_conflict_pulse", {31'd0, conflict}, 32'd0);
        ra1 = 5'd9;
        #1;
        chk("t2_rd_younger", rd1, 32'd2);

        // 3) zero-register suppression
        offer(1'b1, 5'd0, 32'hDEAD_0000, 1'b1, 5'd5, 32'h5555_0005, 1'b1);
        step();
        offer(1'b1, 5'd0, 32'hDEAD_0001, 1'b1, 5'd0, 32'hDEAD_0002, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("t3_count", {29'd0, count}, 32'd0);
        ra1 = 5'd5; ra2 = 5'd0;
        #1;
        chk("t3_rd5", rd1, 32'h5555_0005);
        chk("t3_rd0", rd2, 32'd0);
        drain_wait("t3_drained");

        // 4) fill with drain held off; fifth offer refused
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 5'(10 + i), 32'h4000_0000 + i, 1'b1, 5'(20 + i), 32'h4100_0000 + i, 1'b1);
            step();
        end
        chk("t4_full_count", {29'd0, count}, 32'd4);
        chk("t4_not_ready", {31'd0, in_ready}, 32'd0);
        offer(1'b1, 5'd30, 32'hBAD0_0000, 1'b1, 5'd31, 32'hBAD0_0001, 1'b0);
        step();
        in_valid = 1'b0;
        chk("t4_refused", {29'd0, count}, 32'd4);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_back_to_back", {30'd0, w1_en, w2_en}, 32'd3);
        end
        chk("t4_empty", {29'd0, count}, 32'd0);
        drain_wait("t4_drained");

        // 5) streaming push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 5'(1 + i), 32'h5000_0000 + i, 1'b1, 5'(12 + i), 32'h5100_0000 + i, 1'b1);
            step();
            chk("t5_steady_count", {29'd0, count}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t5_final_count", {29'd0, count}, 32'd0);
        drain_wait("t5_drained");

        // 6a) flush discards queued entries
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 5'(4 + i), 32'h6000_0000 + i, 1'b0, 5'd0, 32'd0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        chk("t6_filled", {29'd0, count}, 32'd3);
        flush = 1'b1;
        drain_en = 1'b1;
        #1;
        chk("t6_flush_not_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        chk("t6_flush_count", {29'd0, count}, 32'd0);
        chk("t6_flush_enables", {29'd0, w1_en, w2_en, conflict}, 32'd0);
        step();
        step();
        chk("t6_stay_empty", {29'd0, count}, 32'd0);

        // 6b) async reset mid-drain
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 5'(24 + i), 32'h7000_0000 + i, 1'b1, 5'(27 + i), 32'h7100_0000 + i, 1'b1);
            step();
        end
        in_valid = 1'b0;
        chk("t6_mid_drain", {31'd0, w1_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_enables", {29'd0, w1_en, w2_en, conflict}, 32'd0);
        chk("t6_rst_count", {29'd0, count}, 32'd0);
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk_t);
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("t6_post_rst_idle", {29'd0, w1_en, w2_en, count[0]}, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
